// File: rtl/addsub_pipe.sv
// addsub_pipe: pipelined two's-complement adder/subtractor, one WIDTH/STAGES slice per stage
//   clk, rst         rising-edge clock, synchronous active-high reset
//   in_valid/ready   operand handshake; a, b operands; m = 0 add, 1 subtract
//   out_valid/ready  result handshake; s result
//   c_final          carry (add) or borrow (sub); ovf signed overflow; zero s == 0; neg s msb
//   ADDSUB_PIPE_SATURATE_EN clamps s to the signed range on overflow
module addsub_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             m,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_final,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);
  localparam int SW  = WIDTH / STAGES;
  localparam int L   = STAGES - 1;
  localparam int MSB = WIDTH - 1;
  logic w_adv;
  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    logic [WIDTH-1:0] w_a, w_bx, w_sum, w_sum_n;
    logic             w_m, w_ci, w_v;
    logic [SW:0]      w_add;
    if (k == 0) begin : g_in
      assign w_a   = a;
      assign w_bx  = b ^ {WIDTH{m}};
      assign w_m   = m;
      assign w_ci  = m;
      assign w_sum = '0;
      assign w_v   = in_valid;
    end else begin : g_mid
      assign w_a   = g_st[k-1].g_reg.r_a;
      assign w_bx  = g_st[k-1].g_reg.r_bx;
      assign w_m   = g_st[k-1].g_reg.r_m;
      assign w_ci  = g_st[k-1].g_reg.r_c;
      assign w_sum = g_st[k-1].g_reg.r_sum;
      assign w_v   = g_st[k-1].g_reg.r_v;
    end
    assign w_add   = {1'b0, w_a[k*SW +: SW]} + {1'b0, w_bx[k*SW +: SW]} + (SW+1)'(w_ci);
    // slices above k are still zero in w_sum, so OR drops this slice in place
    assign w_sum_n = w_sum | (WIDTH'(w_add[SW-1:0]) << (k * SW));
    if (k < L) begin : g_reg
      logic [WIDTH-1:0] r_a, r_bx, r_sum;
      logic             r_m, r_c, r_v;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_v   <= 1'b0;
          r_a   <= '0;
          r_bx  <= '0;
          r_sum <= '0;
          r_m   <= 1'b0;
          r_c   <= 1'b0;
        end else if (w_adv) begin
          r_v   <= w_v;
          r_a   <= w_a;
          r_bx  <= w_bx;
          r_sum <= w_sum_n;
          r_m   <= w_m;
          r_c   <= w_add[SW];
        end
      end
    end
  end
  logic [WIDTH-1:0] w_raw, w_s;
  logic             w_amsb, w_ovf;
  assign w_raw  = g_st[L].w_sum_n;
  assign w_amsb = g_st[L].w_a[MSB];
  assign w_ovf  = (w_amsb == g_st[L].w_bx[MSB]) && (w_raw[MSB] != w_amsb);
`ifdef ADDSUB_PIPE_SATURATE_EN
  logic [WIDTH-1:0] w_min;
  assign w_min = WIDTH'(1) << MSB;
  assign w_s   = w_ovf ? (w_amsb ? w_min : ~w_min) : w_raw;
`else
  assign w_s   = w_raw;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      s         <= '0;
      c_final   <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
    end else if (w_adv) begin
      out_valid <= g_st[L].w_v;
      s         <= w_s;
      c_final   <= g_st[L].w_add[SW] ^ g_st[L].w_m;
      ovf       <= w_ovf;
      zero      <= w_s == '0;
      neg       <= w_s[MSB];
    end
  end
endmodule

// File: tb/tb_addsub_pipe.sv
// tb_addsub_pipe: directed checks of addsub_pipe with 2-stage and 4-stage instances
module tb_addsub_pipe;
  logic        clk = 1'b0;
  logic        rst, in_valid, m, out_ready;
  logic [15:0] a, b;
  logic        in_ready, out_valid, c_final, ovf, zero, neg;
  logic [15:0] s;
  logic        in_ready4, out_valid4, c_final4, ovf4, zero4, neg4;
  logic [15:0] s4;
  int          n_cmp = 0;
  int          n_bad = 0;
  always #5 clk = ~clk;
  addsub_pipe #(.WIDTH(16), .STAGES(2)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .m(m),
    .out_valid(out_valid), .out_ready(out_ready), .s(s), .c_final(c_final), .ovf(ovf),
    .zero(zero), .neg(neg)
  );
  addsub_pipe #(.WIDTH(16), .STAGES(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .a(a), .b(b), .m(m),
    .out_valid(out_valid4), .out_ready(out_ready), .s(s4), .c_final(c_final4), .ovf(ovf4),
    .zero(zero4), .neg(neg4)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic one(input string tag, input logic [15:0] xa, input logic [15:0] xb, input logic xm,
                     input logic [15:0] es, input logic ec, input logic eo, input logic ez, input logic en);
    a = xa;
    b = xb;
    m = xm;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check({tag, ".ov"}, 32'(out_valid), 32'd1);
    check({tag, ".s"}, 32'(s), 32'(es));
    check({tag, ".c"}, 32'(c_final), 32'(ec));
    check({tag, ".ovf"}, 32'(ovf), 32'(eo));
    check({tag, ".zero"}, 32'(zero), 32'(ez));
    check({tag, ".neg"}, 32'(neg), 32'(en));
    step();
  endtask
  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    m = 1'b0;
    step();
    step();
    check("rst.ov", 32'(out_valid), 32'd0);
    check("rst.s", 32'(s), 32'd0);
    check("rst.flags", 32'({c_final, ovf, zero, neg}), 32'd0);
    check("rst.ov4", 32'(out_valid4), 32'd0);
    rst = 1'b0;
    step();
    check("rst.rdy", 32'(in_ready), 32'd1);
    one("sub", 16'h0007, 16'h0009, 1'b1, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b1);
    one("wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
`ifdef ADDSUB_PIPE_SATURATE_EN
    one("ovp", 16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0);
    one("ovn", 16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
`else
    one("ovp", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
    one("ovn", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0);
`endif
    a = 16'd1;
    b = 16'd2;
    m = 1'b0;
    in_valid = 1'b1;
    step();
    a = 16'd10;
    b = 16'd3;
    m = 1'b1;
    step();
    check("bp.ov0", 32'(out_valid), 32'd1);
    check("bp.s0", 32'(s), 32'h3);
    a = 16'h0100;
    b = 16'h00FF;
    m = 1'b0;
    out_ready = 1'b0;
    #1;
    check("bp.rdy", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp.hold.ov", 32'(out_valid), 32'd1);
      check("bp.hold.s", 32'(s), 32'h3);
      check("bp.hold.rdy", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    step();
    check("bp.ov1", 32'(out_valid), 32'd1);
    check("bp.s1", 32'(s), 32'h7);
    a = 16'd5;
    b = 16'd6;
    m = 1'b1;
    step();
    in_valid = 1'b0;
    check("bp.ov2", 32'(out_valid), 32'd1);
    check("bp.s2", 32'(s), 32'h1FF);
    step();
    check("bp.ov3", 32'(out_valid), 32'd1);
    check("bp.s3", 32'(s), 32'hFFFF);
    check("bp.neg3", 32'(neg), 32'd1);
    step();
    check("bp.drain", 32'(out_valid), 32'd0);
    repeat (4) step();
    a = 16'd1;
    b = 16'd1;
    m = 1'b0;
    in_valid = 1'b1;
    step();
    a = 16'd2;
    b = 16'd2;
    step();
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst.ov", 32'(out_valid), 32'd0);
    check("mrst.s", 32'(s), 32'd0);
    check("mrst.flags", 32'({c_final, ovf, zero, neg}), 32'd0);
    check("mrst.ov4", 32'(out_valid4), 32'd0);
    check("mrst.s4", 32'(s4), 32'd0);
    check("mrst.flags4", 32'({c_final4, ovf4, zero4, neg4}), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("mrst.stale", 32'(out_valid), 32'd0);
      check("mrst.stale4", 32'(out_valid4), 32'd0);
    end
    check("mrst.rdy", 32'(in_ready), 32'd1);
    a = 16'h0FFF;
    b = 16'h0001;
    m = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("cc.ov2", 32'(out_valid), 32'd1);
    check("cc.s2", 32'(s), 32'h1000);
    check("cc.early4a", 32'(out_valid4), 32'd0);
    step();
    check("cc.early4b", 32'(out_valid4), 32'd0);
    step();
    check("cc.ov4", 32'(out_valid4), 32'd1);
    check("cc.s4", 32'(s4), 32'h1000);
    check("cc.flags4", 32'({c_final4, ovf4, zero4, neg4}), 32'd0);
    step();
    check("cc.end4", 32'(out_valid4), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/addsub_pipe.md
Name: addsub_pipe

Overview:
- Parametrised, pipelined two's-complement adder/subtractor for generic N-bit datapaths.
- Operand width is split into STAGES equal slices. Each slice is added in its own pipeline stage, and the carry is registered between stages.
- Streaming valid/ready interface on input and output. Per-result status flags: carry/borrow, signed overflow, zero, negative.
- Sits between operand sources (register file, accumulators) and result consumers in the datapath.

Parameters:
- WIDTH, 16, operand/result width in bits; must be divisible by STAGES.
- STAGES, 2, number of pipeline stages (1..WIDTH); slice width SW = WIDTH/STAGES.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block can accept a beat this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- m  input  1  mode: 0 = A+B, 1 = A-B
- out_valid  output  1  result beat valid
- out_ready  input  1  consumer accepts result
- s  output  WIDTH  result
- c_final  output  1  add: carry-out; sub: borrow (carry-out XOR m)
- ovf  output  1  signed overflow
- zero  output  1  s == 0
- neg  output  1  s[WIDTH-1]

Behaviour:
- Reset: synchronous, active-high. All stage valid bits are cleared, and out_valid, s, c_final, ovf, zero and neg are driven to 0. Takes effect on the next clk edge regardless of handshake state; in-flight beats are discarded. in_ready = 1 the cycle after rst is deasserted.
- Arithmetic:
  - Subtraction is B' = b XOR {WIDTH{m}}, carry-in = m.
  - Stage k (0-based) adds slice k of A and B' plus the carry registered from stage k-1 (stage 0 uses m).
- Operand skew: slices above k are carried forward in skew registers so that every slice of one beat meets its carry. The results of lower slices are carried forward so the full s appears together.
- Flags, computed in the final stage from the full WIDTH result:
  - c_final = cout XOR m.
  - ovf = (A[msb] == B'[msb]) AND (s_raw[msb] != A[msb]).
  - zero and neg are computed on the final (post-saturation, if enabled) s.
- Latency: exactly STAGES cycles from an accepted input beat to out_valid with no backpressure. Throughput is 1 beat/cycle.
- Handshake:
  - A beat is accepted when in_valid && in_ready.
  - A result is transferred when out_valid && out_ready.
  - advance = !out_valid || out_ready, and in_ready = advance. The whole pipeline holds when advance = 0.
  - Empty (bubble) stages are not collapsed.
- Output stability: while out_valid = 1 and out_ready = 0, s, c_final, ovf, zero and neg hold stable.
- Simultaneous accept and transfer in the same cycle: both occur; no beat is lost or duplicated.
- Pipeline contents: a, b and m are sampled only on accept. Each stage holds its own m copy, so mixed add/sub beats stream back-to-back.
- Wrap-around: the result is modulo 2^WIDTH. No state is retained between beats.
- STAGES = 1: a single registered adder with latency 1.

Optional Feature:
- Macro: ADDSUB_PIPE_SATURATE_EN.
- When defined: if ovf = 1, s is clamped to 0x7F..F (positive overflow, A[msb] = 0) or 0x80..0 (negative overflow). ovf and c_final still report the unsaturated condition; zero and neg reflect the clamped s. Latency is unchanged.
- When undefined: s is the wrapped result; no clamp logic is present.

Test Plan (WIDTH=16, STAGES=2 unless noted):
- Basic subtract: a=0x0007, b=0x0009, m=1, out_ready=1 -> after 2 cycles out_valid=1, s=0xFFFE, c_final=1, neg=1, ovf=0, zero=0.
- Unsigned wrap: a=0xFFFF, b=0x0001, m=0 -> s=0x0000, c_final=1, zero=1, ovf=0.
- Signed overflow: a=0x7FFF, b=0x0001, m=0 -> s=0x8000, ovf=1, neg=1, c_final=0.
  - Then a=0x8000, b=0x0001, m=1 -> s=0x7FFF, ovf=1, c_final=0.
  - With ADDSUB_PIPE_SATURATE_EN: results are 0x7FFF and 0x8000 respectively, ovf=1.
- Backpressure: stream 4 beats of alternating m; hold out_ready=0 for 3 cycles after the first out_valid.
  - Required: in_ready=0 during the stall and s stable.
  - Required: results emerge in order with no loss/duplication.
  - Required: 1 beat/cycle after out_ready returns.
- Reset mid-operation: accept 2 beats, assert rst for 1 cycle before any output -> out_valid=0, all outputs 0, no stale result ever appears. A new beat afterwards emerges with latency 2.
- STAGES=4, WIDTH=16 carry chain: a=0x0FFF, b=0x0001, m=0 -> s=0x1000 after 4 cycles, confirming carry propagates across every stage boundary.
